// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line types, levels and default frame parameters
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL   = 1'b1;
  localparam int   UART_CLKS_PER_BIT = 16;
  localparam int   UART_DATA_BITS    = 8;

  // Counter width able to hold 0..clks-1, never narrower than one bit.
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter, 0..CLKS_PER_BIT-1 with terminal-count pulse
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk2,
  input  logic a_reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW       = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk2 or posedge a_reset) begin
    if (a_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == TERMINAL) ? '0 : count + CW'(1);
    end
  end

  assign tick = enable && !clear && (count == TERMINAL);

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmitter: start bit, LSB-first data, one stop bit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk2,
  input  logic                 a_reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_serial
);

  localparam int            IW       = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IW-1:0]        bit_idx;
  logic                 bit_tick;
  logic                 timer_clear;
  logic                 timer_enable;

  // The timer idles at zero so a freshly accepted frame starts a full bit period.
  assign timer_clear  = (state == IDLE);
  assign timer_enable = (state != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk2   (clk2),
    .a_reset(a_reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tick   (bit_tick)
  );

  always_ff @(posedge clk2 or posedge a_reset) begin
    if (a_reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx_serial <= UART_IDLE_LEVEL;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= UART_IDLE_LEVEL;
          tx_busy   <= 1'b0;
          if (tx_start) begin
            shift_reg <= tx_data;
            state     <= START;
            tx_serial <= ~UART_IDLE_LEVEL;
            tx_busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state     <= DATA;
            tx_serial <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_idx   <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
              state     <= STOP;
              tx_serial <= UART_IDLE_LEVEL;
            end else begin
              tx_serial <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + IW'(1);
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            tx_done <= 1'b1;
            // A waiting request chains straight into the next start bit, no idle gap.
            if (tx_start) begin
              shift_reg <= tx_data;
              state     <= START;
              tx_serial <= ~UART_IDLE_LEVEL;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= UART_IDLE_LEVEL;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int FRAME = (DB + 2) * CPB;

  logic          clk2     = 1'b0;
  logic          a_reset  = 1'b0;
  logic          tx_start = 1'b0;
  logic [DB-1:0] tx_data  = '0;
  logic          tx_busy;
  logic          tx_done;
  logic          tx_serial;

  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en   = 1'b0;

  logic ser [200];
  logic bsy [200];
  logic dn  [200];

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk2     (clk2),
    .a_reset  (a_reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_serial(tx_serial)
  );

  always #5 clk2 = ~clk2;

  // Frame-position model: where in the 40-cycle frame the line is after each edge.
  typedef struct packed {
    logic          active;
    logic [7:0]    pos;
    logic          done;
    logic [DB-1:0] data;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t s, logic start, logic [DB-1:0] d);
    model_t n;
    n      = s;
    n.done = 1'b0;
    if (n.active) begin
      n.pos = n.pos + 8'd1;
      if (int'(n.pos) == FRAME) begin
        n.active = 1'b0;
        n.done   = 1'b1;
      end
    end
    if (!n.active && start) begin
      n.active = 1'b1;
      n.pos    = '0;
      n.data   = d;
    end
    return n;
  endfunction

  function automatic logic exp_line(int p, logic [DB-1:0] d);
    if (p < CPB) return 1'b0;
    if (p < (DB + 1) * CPB) return d[(p - CPB) / CPB];
    return 1'b1;
  endfunction

  always @(posedge clk2 or posedge a_reset) begin
    if (a_reset) m <= '0;
    else         m <= model_step(m, tx_start, tx_data);
  end

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk2) begin
    if (chk_en) begin
      check("busy", {31'd0, tx_busy}, {31'd0, m.active});
      check("serial", {31'd0, tx_serial},
            {31'd0, (m.active ? exp_line(int'(m.pos), m.data) : 1'b1)});
      check("done", {31'd0, tx_done}, {31'd0, m.done});
    end
  end

  task automatic sample(int i);
    ser[i] = tx_serial;
    bsy[i] = tx_busy;
    dn[i]  = tx_done;
  endtask

  function automatic int busy_cycles(int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (bsy[i]) c++;
    return c;
  endfunction

  function automatic int done_count(int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (dn[i]) c++;
    return c;
  endfunction

  function automatic int low_count(int from, int n);
    int c = 0;
    for (int i = from; i < from + n; i++) if (!ser[i]) c++;
    return c;
  endfunction

  function automatic logic [DB-1:0] line_byte(int base);
    logic [DB-1:0] v;
    for (int b = 0; b < DB; b++) v[b] = ser[base + CPB * (b + 1) + CPB / 2];
    return v;
  endfunction

  initial begin
    logic [9:0] line10;

    // Reset takes effect before any clock edge, then a quiet idle line.
    #1 a_reset = 1'b1;
    #1;
    check("reset_serial", {31'd0, tx_serial}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_done", {31'd0, tx_done}, 32'd0);
    repeat (3) @(negedge clk2);
    a_reset = 1'b0;
    chk_en  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk2);
      sample(i);
    end
    check("idle_line_low", low_count(0, 20), 0);
    check("idle_busy", busy_cycles(20), 0);
    check("idle_done", done_count(20), 0);

    // Single 0xA5 frame.
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk2);
      if (i == 0) tx_start = 1'b0;
      sample(i);
    end
    for (int b = 0; b < 10; b++) line10[b] = ser[CPB * b + CPB / 2];
    check("a5_line", {22'd0, line10}, 32'h34A);
    check("a5_busy_cycles", busy_cycles(50), 40);
    check("a5_done_at_40", {31'd0, dn[40]}, 32'd1);
    check("a5_done_count", done_count(50), 1);

    // Request and data change during a frame are ignored.
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk2);
      if (i == 0) tx_start = 1'b0;
      if (i == 9) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end
      if (i == 10) tx_start = 1'b0;
      sample(i);
    end
    check("busy_rej_byte", {24'd0, line_byte(0)}, 32'h3C);
    check("busy_rej_busy", busy_cycles(90), 40);
    check("busy_rej_done", done_count(90), 1);

    // Held request: two contiguous frames.
    tx_data  = 8'h01;
    tx_start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk2);
      if (i == 0) tx_data = 8'h80;
      if (i == 40) tx_start = 1'b0;
      sample(i);
    end
    check("b2b_byte0", {24'd0, line_byte(0)}, 32'h01);
    check("b2b_byte1", {24'd0, line_byte(FRAME)}, 32'h80);
    check("b2b_done_40", {31'd0, dn[40]}, 32'd1);
    check("b2b_done_80", {31'd0, dn[80]}, 32'd1);
    check("b2b_done_count", done_count(100), 2);
    check("b2b_busy", busy_cycles(100), 80);
    check("b2b_start_at_40", {31'd0, ser[40]}, 32'd0);

    // Asynchronous reset in the middle of a frame.
    tx_data  = 8'h00;
    tx_start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk2);
      if (i == 0) tx_start = 1'b0;
      sample(i);
    end
    #2 a_reset = 1'b1;
    #1;
    check("midrst_serial", {31'd0, tx_serial}, 32'd1);
    check("midrst_busy", {31'd0, tx_busy}, 32'd0);
    check("midrst_no_done", done_count(17), 0);
    @(negedge clk2);
    check("midrst_done_in_rst", {31'd0, tx_done}, 32'd0);
    @(negedge clk2);
    a_reset  = 1'b0;
    tx_data  = 8'h55;
    tx_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk2);
      if (i == 0) tx_start = 1'b0;
      sample(i);
    end
    check("post_rst_start", {31'd0, ser[0]}, 32'd0);
    check("post_rst_byte", {24'd0, line_byte(0)}, 32'h55);
    check("post_rst_done", done_count(50), 1);

    // All-zero and all-one data.
    tx_data  = 8'h00;
    tx_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk2);
      if (i == 0) tx_start = 1'b0;
      sample(i);
    end
    check("zero_low_cycles", low_count(0, 50), 36);
    check("zero_stop", {31'd0, ser[38]}, 32'd1);
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk2);
      if (i == 0) tx_start = 1'b0;
      sample(i);
    end
    check("ones_low_cycles", low_count(0, 50), 4);
    check("ones_stop", {31'd0, ser[38]}, 32'd1);
    check("ones_done", done_count(50), 1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
